led_activity_driver: RTL and testbench

//  Drives the board status LED (pin_led) from the internal-oscillator clock domain.

---
 rtl/led_activity_driver.sv | 128 ++++++++++++
 tb/tb_led_activity_driver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/led_activity_driver.sv
// Status LED driver: idle heartbeat, stretched activity indication, sticky error blink.
// Single clock domain with a synchronous active-high reset.
module led_activity_driver #(
  parameter int TICK_DIV        = 2080,
  parameter int STRETCH_MS      = 50,
  parameter int BLINK_MS        = 125,
  parameter int HEARTBEAT_MS    = 1000,
  parameter int HEARTBEAT_ON_MS = 50,
  parameter int PWM_BITS        = 4,
  parameter int IDLE_DUTY       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activity,
  input  logic       error_set,
  input  logic       error_clr,
  output logic       pin_led,
  output logic [1:0] led_state
);

  localparam int MS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ST_W = $clog2(STRETCH_MS + 1);
  localparam int BL_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int PH_W = (HEARTBEAT_MS > 1) ? $clog2(HEARTBEAT_MS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [ST_W-1:0]     stretch_q, stretch_d;
  logic [PH_W-1:0]     phase_cnt_q, phase_cnt_d;
  logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_on_q, blink_on_d;
  logic                pin_led_q, pin_led_d;
  logic                tick;
  logic                hb_lit;
  logic                pwm_lit;

  assign tick = (ms_cnt_q == MS_W'(TICK_DIV - 1));

  // Extra MSB so an ON/duty value equal to the full range compares correctly.
  assign hb_lit  = ({1'b0, phase_cnt_q} < (PH_W + 1)'(HEARTBEAT_ON_MS));
  assign pwm_lit = ({1'b0, pwm_cnt_q} < (PWM_BITS + 1)'(IDLE_DUTY));

  always_comb begin
    ms_cnt_d    = tick ? '0 : ms_cnt_q + 1'b1;
    pwm_cnt_d   = pwm_cnt_q + 1'b1;

    stretch_d   = stretch_q;
    if (activity)
      stretch_d = ST_W'(STRETCH_MS);
    else if (tick && (stretch_q != '0))
      stretch_d = stretch_q - 1'b1;

    phase_cnt_d = phase_cnt_q;
    if (tick)
      phase_cnt_d = (phase_cnt_q == PH_W'(HEARTBEAT_MS - 1)) ?
                    '0 : phase_cnt_q + 1'b1;

    if (error_set)
      state_d = S_ERROR;
    else if ((state_q == S_ERROR) && !error_clr)
      state_d = S_ERROR;
    else if (stretch_d != '0)
      state_d = S_ACTIVE;
    else
      state_d = S_IDLE;

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if ((state_q == S_ERROR) && tick) begin
      if (blink_cnt_q == BL_W'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // LED follows the registered mode, so it lags led_state by one cycle.
    pin_led_d = 1'b0;
    unique case (state_q)
      S_IDLE:   pin_led_d = hb_lit && pwm_lit;
      S_ACTIVE: pin_led_d = 1'b1;
      S_ERROR:  pin_led_d = blink_on_q;
      default:  pin_led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ms_cnt_q    <= '0;
      pwm_cnt_q   <= '0;
      stretch_q   <= '0;
      phase_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      pin_led_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      stretch_q   <= stretch_d;
      phase_cnt_q <= phase_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      pin_led_q   <= pin_led_d;
    end
  end

  assign pin_led   = pin_led_q;
  assign led_state = state_q;

  a_hb_on: assert property (@(posedge clk)
    HEARTBEAT_ON_MS <= HEARTBEAT_MS);
  a_duty: assert property (@(posedge clk)
    IDLE_DUTY <= (1 << PWM_BITS));

endmodule

// File: tb/tb_led_activity_driver.sv
// Directed bench for led_activity_driver with small timing parameters.
// Idle and error-blink patterns use closed-form expectations; the rest is a vector table.
module tb_led_activity_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       activity = 1'b0;
  logic       error_set = 1'b0;
  logic       error_clr = 1'b0;
  logic       pin_led;
  logic [1:0] led_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_activity_driver #(
    .TICK_DIV       (4),
    .STRETCH_MS     (3),
    .BLINK_MS       (2),
    .HEARTBEAT_MS   (8),
    .HEARTBEAT_ON_MS(2),
    .PWM_BITS       (2),
    .IDLE_DUTY      (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .activity (activity),
    .error_set(error_set),
    .error_clr(error_clr),
    .pin_led  (pin_led),
    .led_state(led_state)
  );

  typedef struct {
    logic       rst;
    logic       act;
    logic       set;
    logic       clr;
    int         reps;
    logic [1:0] st;
    logic       led;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic r, input logic a, input logic s, input logic c);
    reset     = r;
    activity  = a;
    error_set = s;
    error_clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset_state", int'(led_state), 0);
      chk("reset_led", int'(pin_led), 0);
    end
  endtask

  task automatic chk_internal_zero();
    chk("rst_ms_cnt", int'(dut.ms_cnt_q), 0);
    chk("rst_pwm_cnt", int'(dut.pwm_cnt_q), 0);
    chk("rst_stretch", int'(dut.stretch_q), 0);
    chk("rst_phase", int'(dut.phase_cnt_q), 0);
    chk("rst_blink_cnt", int'(dut.blink_cnt_q), 0);
    chk("rst_blink_on", int'(dut.blink_on_q), 0);
  endtask

  initial begin
    int k;
    int exp_led;

    @(negedge clk);

    // Idle heartbeat: after edge k, LED reflects counters after edge k-1.
    do_reset();
    chk_internal_zero();
    for (k = 1; k <= 64; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      exp_led = (((k - 1) % 4) == 0) && ((((k - 1) / 4) % 8) < 2);
      chk("idle_state", int'(led_state), 0);
      chk("idle_led", int'(pin_led), exp_led);
    end

    // Error blink: set at edge 1, blink_on toggles every 2 ticks = 8 cycles.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("err_enter_state", int'(led_state), 2);
    chk("err_enter_led", int'(pin_led), 1);
    for (k = 2; k <= 65; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      exp_led = ((((k - 1) / 8) % 2) == 0);
      chk("err_state", int'(led_state), 2);
      chk("err_blink_led", int'(pin_led), exp_led);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_clr_state", int'(led_state), 0);

    // Table: edge numbers below count from the end of reset.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  2'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8,  2'd1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2,  2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  2'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8,  2'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  2'd1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 11, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  2'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  2'd0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1,  2'd2, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  2'd1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  2'd2, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        if (tbl[i].rst) begin
          chk("pre_rst_stretch", int'(dut.stretch_q), 2);
          chk("pre_rst_state", int'(led_state), 2);
        end
        step(tbl[i].rst, tbl[i].act, tbl[i].set, tbl[i].clr);
        chk($sformatf("vec%0d_state", i), int'(led_state), int'(tbl[i].st));
        chk($sformatf("vec%0d_led", i), int'(pin_led), int'(tbl[i].led));
        if (tbl[i].rst) chk_internal_zero();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
